dcache_responder: RTL and testbench

Direct-mapped, write-through, read-allocate data cache that terminates the core's cache request port (the responder side of `cache_req_*` / `cache_rsp_*`) and forwards misses and writes to a word-addressed backing memory port. It sits between the core top level and the DRAM controller. It accepts one request at a time: at most one request is outstanding and responses return in order.

---
 rtl/dcache_responder.sv | 155 +++++++++++++++
 tb/tb_dcache_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, read-allocate data cache with one request in flight.
// Define DCACHE_STATS_EN to enable the read hit/miss counters (tied to 0 otherwise).
module dcache_responder #(
    parameter int ADDR_W     = 25,
    parameter int INDEX_BITS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic              req_wr,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_valid,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int TAG_W = ADDR_W - INDEX_BITS;
    localparam int DEPTH = 1 << INDEX_BITS;

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, WRITE_REQ, RESP} state_t;

    // req_wr polarity is kept as on the port: 1 = read, 0 = write
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              wr;
    } req_t;

    state_t                state, state_nx;
    req_t                  lat_req;
    logic [INDEX_BITS-1:0] init_idx;
    logic [DEPTH-1:0]      valid;
    logic [31:0]           data_mem [DEPTH];
    logic [TAG_W-1:0]      tag_mem  [DEPTH];
    logic [31:0]           rd_data;
    logic [TAG_W-1:0]      rd_tag;
    logic [31:0]           rsp_q;

    logic [INDEX_BITS-1:0] req_idx, lat_idx;
    logic [TAG_W-1:0]      lat_tag;
    logic                  accept, hit, is_read, wr_hit, fill;

    assign req_idx = req_addr[INDEX_BITS-1:0];
    assign lat_idx = lat_req.addr[INDEX_BITS-1:0];
    assign lat_tag = lat_req.addr[ADDR_W-1:INDEX_BITS];
    assign is_read = lat_req.wr;
    assign accept  = (state == IDLE) && req_valid;
    assign hit     = valid[lat_idx] && (rd_tag == lat_tag);
    // Gated by reset so a response racing a reset cannot touch the arrays
    assign wr_hit  = reset && (state == LOOKUP) && !is_read && hit;
    assign fill    = reset && (state == MISS_WAIT) && mem_rvalid;

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = lat_req.addr;
        mem_wdata = lat_req.data;
        rsp_data  = rsp_q;
        case (state)
            INIT:      if (&init_idx) state_nx = IDLE;
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = LOOKUP;
            end
            LOOKUP: begin
                if (!is_read)  state_nx = WRITE_REQ;
                else if (hit)  state_nx = RESP;
                else           state_nx = MISS_REQ;
            end
            MISS_REQ: begin
                mem_valid = 1'b1;
                if (mem_ready) state_nx = MISS_WAIT;
            end
            MISS_WAIT: if (mem_rvalid) state_nx = RESP;
            WRITE_REQ: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                if (mem_ready) state_nx = IDLE;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            default:   state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= INIT;
            init_idx <= '0;
            lat_req  <= '0;
            rsp_q    <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) init_idx <= init_idx + 1'b1;
            if (accept) lat_req <= '{addr: req_addr, data: req_data, wr: req_wr};
            if ((state == LOOKUP) && is_read && hit) rsp_q <= rd_data;
            if (fill) rsp_q <= mem_rdata;
        end
    end

    // Valid bits are cleared by the INIT walk rather than a reset fan-out
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == INIT) valid[init_idx] <= 1'b0;
            else if (fill)     valid[lat_idx]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_data <= data_mem[req_idx];
            rd_tag  <= tag_mem[req_idx];
        end
        if (wr_hit) begin
            data_mem[lat_idx] <= lat_req.data;
        end else if (fill) begin
            data_mem[lat_idx] <= mem_rdata;
            tag_mem[lat_idx]  <= lat_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if ((state == LOOKUP) && is_read) begin
            if (hit) hits_q   <= hits_q + 1'b1;
            else     misses_q <= misses_q + 1'b1;
        end
    end

    assign hit_count  = hits_q;
    assign miss_count = misses_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// Directed, table-driven bench for dcache_responder (INDEX_BITS=4) with a backing-memory responder.
module tb_dcache_responder;
    localparam int AW = 25;
    localparam int IB = 4;
`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic          req_wr, req_valid, req_ready;
    logic [31:0]   rsp_data;
    logic          rsp_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we, mem_valid, mem_ready;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;
    logic [31:0]   hit_count, miss_count;

    always #5 clk = ~clk;

    dcache_responder #(.ADDR_W(AW), .INDEX_BITS(IB)) dut (
        .clk(clk), .reset(reset),
        .req_addr(req_addr), .req_data(req_data), .req_wr(req_wr),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {
        logic          rd;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            lat;
        int            exp_mrd;
        logic [31:0]   exp_rsp;
        int            exp_hits;
        int            exp_miss;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    logic [31:0] bmem [int];
    int n_chk = 0;
    int n_err = 0;

    int            r_rsp_cnt, r_rsp_lat, r_mrd, r_mwr, r_first_mv, r_hs_cyc, r_rv_cyc, r_ready_cyc;
    logic [31:0]   r_rsp_d, r_mwd;
    logic [AW-1:0] r_maddr;
    logic          r_unstable;
    int            i_cnt, i_bad;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmem_rd(input logic [AW-1:0] a);
        if (bmem.exists(int'(a))) return bmem[int'(a)];
        return 32'hBAD00000 ^ 32'(a);
    endfunction

    // Issues one request and plays the backing memory (ready after a one-cycle stall).
    // Cycle numbers count negedges after the accepting edge.
    task automatic run_req(input logic rd, input logic [AW-1:0] addr, input logic [31:0] data,
                           input int lat);
        int   stall, rv_due;
        logic hs_we;
        r_rsp_cnt = 0; r_rsp_lat = -1; r_mrd = 0; r_mwr = 0; r_first_mv = -1;
        r_hs_cyc = -1; r_rv_cyc = -1; r_ready_cyc = -1; r_unstable = 1'b0;
        r_rsp_d = '0; r_mwd = '0; r_maddr = '0;
        stall = 0; rv_due = -1; hs_we = 1'b0;
        for (int t = 0; t < 200 && !req_ready; t++) @(negedge clk);
        req_valid = 1'b1; req_wr = rd; req_addr = addr; req_data = data;
        @(posedge clk);
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            mem_rvalid = 1'b0;
            if (mem_ready) begin
                mem_ready = 1'b0;
                if (hs_we) bmem[int'(r_maddr)] = r_mwd;
                else       rv_due = cyc + lat - 1;
            end
            if (rsp_valid) begin
                r_rsp_cnt++; r_rsp_d = rsp_data; r_rsp_lat = cyc;
            end
            if (mem_valid) begin
                if (r_first_mv < 0) begin
                    r_first_mv = cyc; r_maddr = mem_addr; r_mwd = mem_wdata;
                end else if (mem_addr != r_maddr || mem_wdata != r_mwd) begin
                    r_unstable = 1'b1;
                end
                stall++;
                if (stall == 2) begin
                    mem_ready = 1'b1; hs_we = mem_we; r_hs_cyc = cyc; stall = 0;
                    if (mem_we) r_mwr++; else r_mrd++;
                end
            end
            if (cyc == rv_due) begin
                mem_rvalid = 1'b1; mem_rdata = bmem_rd(r_maddr); r_rv_cyc = cyc;
            end
            if (req_ready) begin
                r_ready_cyc = cyc;
                break;
            end
        end
    endtask

    // Counts negedges until req_ready, flagging any mem_valid/rsp_valid seen meanwhile
    task automatic init_wait();
        i_cnt = -1; i_bad = 0;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (mem_valid || rsp_valid) i_bad++;
            if (req_ready) begin
                i_cnt = k;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] last_rsp;
        vec_t v;
        reset = 1'b0; req_addr = '0; req_data = '0; req_wr = 1'b0; req_valid = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
        last_rsp = '0;

        bmem[32'h123]     = 32'hDEADBEEF;
        bmem[32'h133]     = 32'hCAFE0133;
        bmem[32'h1FFFFFF] = 32'h5A5A5A5A;
        bmem[32'h0]       = 32'h00C0FFEE;
        bmem[32'h156]     = 32'h01560156;

        //            rd    addr          data          lat mrd rsp           hits miss
        vec[0]  = '{1'b1, 25'h0000123, 32'h0,        5, 1, 32'hDEADBEEF, 0, 1};
        vec[1]  = '{1'b1, 25'h0000123, 32'h0,        5, 0, 32'hDEADBEEF, 1, 1};
        vec[2]  = '{1'b0, 25'h0000123, 32'h12345678, 1, 0, 32'h0,        1, 1};
        vec[3]  = '{1'b1, 25'h0000123, 32'h0,        1, 0, 32'h12345678, 2, 1};
        vec[4]  = '{1'b1, 25'h0000133, 32'h0,        2, 1, 32'hCAFE0133, 2, 2};
        vec[5]  = '{1'b1, 25'h0000123, 32'h0,        3, 1, 32'h12345678, 2, 3};
        vec[6]  = '{1'b0, 25'h0000145, 32'h0BADF00D, 1, 0, 32'h0,        2, 3};
        vec[7]  = '{1'b1, 25'h0000145, 32'h0,        1, 1, 32'h0BADF00D, 2, 4};
        vec[8]  = '{1'b1, 25'h0000145, 32'h0,        1, 0, 32'h0BADF00D, 3, 4};
        vec[9]  = '{1'b0, 25'h0000133, 32'h11112222, 1, 0, 32'h0,        3, 4};
        vec[10] = '{1'b1, 25'h0000123, 32'h0,        1, 0, 32'h12345678, 4, 4};
        vec[11] = '{1'b1, 25'h1FFFFFF, 32'h0,        1, 1, 32'h5A5A5A5A, 4, 5};
        vec[12] = '{1'b1, 25'h1FFFFFF, 32'h0,        1, 0, 32'h5A5A5A5A, 5, 5};
        vec[13] = '{1'b1, 25'h0000133, 32'h0,        4, 1, 32'h11112222, 5, 6};
        vec[14] = '{1'b1, 25'h0000000, 32'h0,        3, 1, 32'h00C0FFEE, 5, 7};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", req_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_data", rsp_data, 0);
        chk("rst mem_valid", mem_valid, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst hit_count", hit_count, 0);
        chk("rst miss_count", miss_count, 0);

        reset = 1'b1;
        init_wait();
        chk("init cycles", i_cnt, 16);
        chk("init quiet", i_bad, 0);

        for (int i = 0; i < NV; i++) begin
            v = vec[i];
            run_req(v.rd, v.addr, v.data, v.lat);
            chk($sformatf("v%0d done", i), r_ready_cyc > 0, 1);
            if (v.rd) begin
                chk($sformatf("v%0d rsp_cnt", i), r_rsp_cnt, 1);
                chk($sformatf("v%0d rsp_data", i), r_rsp_d, v.exp_rsp);
                chk($sformatf("v%0d mem_rd", i), r_mrd, v.exp_mrd);
                chk($sformatf("v%0d mem_wr", i), r_mwr, 0);
                if (v.exp_mrd == 0) begin
                    chk($sformatf("v%0d hit_lat", i), r_rsp_lat, 2);
                end else begin
                    chk($sformatf("v%0d miss_lat", i), r_rsp_lat, r_rv_cyc + 1);
                    chk($sformatf("v%0d mem_addr", i), r_maddr, v.addr);
                end
                chk($sformatf("v%0d ready_lat", i), r_ready_cyc, r_rsp_lat + 1);
                last_rsp = v.exp_rsp;
            end else begin
                chk($sformatf("v%0d rsp_cnt", i), r_rsp_cnt, 0);
                chk($sformatf("v%0d mem_wr", i), r_mwr, 1);
                chk($sformatf("v%0d mem_rd", i), r_mrd, 0);
                chk($sformatf("v%0d mem_addr", i), r_maddr, v.addr);
                chk($sformatf("v%0d mem_wdata", i), r_mwd, v.data);
                chk($sformatf("v%0d mv_lat", i), r_first_mv, 2);
                chk($sformatf("v%0d ready_lat", i), r_ready_cyc, r_hs_cyc + 1);
                chk($sformatf("v%0d rsp_hold", i), rsp_data, last_rsp);
            end
            chk($sformatf("v%0d mem_stable", i), r_unstable, 0);
            chk($sformatf("v%0d hit_count", i), hit_count, STATS ? v.exp_hits : 0);
            chk($sformatf("v%0d miss_count", i), miss_count, STATS ? v.exp_miss : 0);
        end

        // Stray mem_rvalid while idle must not produce a response
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stray rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("stray rsp_valid2", rsp_valid, 0);
        chk("stray rsp_data", rsp_data, last_rsp);

        // Reset during MISS_WAIT, then a late mem_rvalid
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 25'h156; req_data = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 20 && !mem_valid; k++) @(negedge clk);
        chk("mr mem_valid", mem_valid, 1);
        chk("mr mem_we", mem_we, 0);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("mr init mem_valid", mem_valid, 0);
        chk("mr init rsp_valid", rsp_valid, 0);
        chk("mr init req_ready", req_ready, 0);
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
        init_wait();
        chk("mr init cycles", i_cnt, 16);
        chk("mr init quiet", i_bad, 0);
        chk("mr hit_count", hit_count, 0);
        chk("mr miss_count", miss_count, 0);
        run_req(1'b1, 25'h156, 32'h0, 2);
        chk("mr reread mem_rd", r_mrd, 1);
        chk("mr reread rsp_cnt", r_rsp_cnt, 1);
        chk("mr reread rsp_data", r_rsp_d, 32'h01560156);
        chk("mr reread miss_count", miss_count, STATS ? 1 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
